// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyphs (bits6:0 = g..a), scan FSM states, slot record.
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_C     = 7'h46;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_E     = 7'h06;
    localparam logic [6:0] GLYPH_F     = 7'h0E;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    typedef enum logic [1:0] {WAIT, SETTLING, HOLD} scan_state_t;

    typedef struct packed {
        logic [3:0] nibble;
        logic       err;
        logic       blank;
        logic       dp;
    } slot_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Inverse of the glyph encoder: active-low 7-bit pattern -> {nibble, err, blank}.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       err,
    output logic       blank
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b0;
        blank  = 1'b0;
        case (pattern)
            GLYPH_0:     nibble = 4'h0;
            GLYPH_1:     nibble = 4'h1;
            GLYPH_2:     nibble = 4'h2;
            GLYPH_3:     nibble = 4'h3;
            GLYPH_4:     nibble = 4'h4;
            GLYPH_5:     nibble = 4'h5;
            GLYPH_6:     nibble = 4'h6;
            GLYPH_7:     nibble = 4'h7;
            GLYPH_8:     nibble = 4'h8;
            GLYPH_9:     nibble = 4'h9;
            GLYPH_A:     nibble = 4'hA;
            GLYPH_B:     nibble = 4'hB;
            GLYPH_C:     nibble = 4'hC;
            GLYPH_D:     nibble = 4'hD;
            GLYPH_E:     nibble = 4'hE;
            GLYPH_F:     nibble = 4'hF;
            GLYPH_BLANK: blank  = 1'b1;
            default:     err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, debounces each digit dwell and
// assembles decoded frames of NUM_DIGITS nibbles with per-digit err/blank/dp flags.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SETTLE     = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic [1:0]              KEY,
    input  logic [7:0]              SEG,
    input  logic [NUM_DIGITS-1:0]   DIG,
    output logic [4*NUM_DIGITS-1:0] VALUE,
    output logic                    FRAME_VALID,
    output logic [NUM_DIGITS-1:0]   ERR,
    output logic [NUM_DIGITS-1:0]   BLANK,
    output logic [NUM_DIGITS-1:0]   DP,
    output logic                    TIMEOUT_FLAG
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT);

    logic gclk, grst_n;
    assign gclk   = KEY[1];
    assign grst_n = KEY[0];

    scan_state_t                  state;
    logic [CW-1:0]                cnt;
    logic [TW-1:0]                idle_cnt;
    logic [7+NUM_DIGITS:0]        s_q;
    logic [NUM_DIGITS-1:0]        seen, seen_nx, sel;
    slot_t [NUM_DIGITS-1:0]       slots, slots_nx, frame;
    slot_t                        cur;
    logic                         legal, same, accept, frame_done;
    logic [3:0]                   dec_nib;
    logic                         dec_err, dec_blank;

    seg7_glyph_decode u_dec (
        .pattern (SEG[6:0]),
        .nibble  (dec_nib),
        .err     (dec_err),
        .blank   (dec_blank)
    );

    assign sel    = ~DIG;
    assign legal  = ($countones(sel) == 1);
    assign same   = ({SEG, DIG} == s_q);
    // The edge that would lift the count to SETTLE is the accept edge.
    assign accept = legal && (state == SETTLING) && same && (cnt == CW'(SETTLE - 1));
    assign cur    = '{nibble: dec_nib, err: dec_err, blank: dec_blank, dp: ~SEG[7]};

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
        assign slots_nx[i]       = (accept && sel[i]) ? cur : slots[i];
        assign VALUE[4*i +: 4]   = frame[i].nibble;
        assign ERR[i]            = frame[i].err;
        assign BLANK[i]          = frame[i].blank;
        assign DP[i]             = frame[i].dp;
    end

    assign seen_nx    = seen | (accept ? sel : '0);
    assign frame_done = accept && (&seen_nx);

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            state <= WAIT;
            cnt   <= '0;
            s_q   <= '0;
        end else begin
            s_q <= {SEG, DIG};
            if (!legal) begin
                state <= WAIT;
                cnt   <= '0;
            end else begin
                case (state)
                    WAIT: begin
                        state <= SETTLING;
                        cnt   <= CW'(1);
                    end
                    SETTLING: begin
                        if (!same) begin
                            cnt <= CW'(1);
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (accept) state <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (!same) begin
                            state <= SETTLING;
                            cnt   <= CW'(1);
                        end
                    end
                    default: begin
                        state <= WAIT;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge gclk or negedge grst_n) begin
        if (!grst_n) begin
            slots        <= '0;
            frame        <= '0;
            seen         <= '0;
            idle_cnt     <= '0;
            FRAME_VALID  <= 1'b0;
            TIMEOUT_FLAG <= 1'b0;
        end else begin
            FRAME_VALID <= 1'b0;
            slots       <= slots_nx;
            if (accept)
                idle_cnt <= '0;
            else if (idle_cnt != TW'(TIMEOUT - 1))
                idle_cnt <= idle_cnt + 1'b1;

            // An accept always wins over a timeout on the same edge.
            if (frame_done) begin
                frame        <= slots_nx;
                seen         <= '0;
                FRAME_VALID  <= 1'b1;
                TIMEOUT_FLAG <= 1'b0;
            end else if (accept) begin
                seen <= seen_nx;
            end else if (idle_cnt == TW'(TIMEOUT - 1) && seen != '0) begin
                seen         <= '0;
                TIMEOUT_FLAG <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: scans, short dwells, blank/err/dp, illegal selects, timeout, reset.
module tb_seg7_scan_decoder;

    localparam int N = 6;

    logic            clk, rst_n;
    logic [7:0]      seg;
    logic [N-1:0]    dig;
    logic [4*N-1:0]  value;
    logic            frame_valid, timeout_flag;
    logic [N-1:0]    err, blank, dp;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int fv_base;

    seg7_scan_decoder #(.NUM_DIGITS(N), .SETTLE(4), .TIMEOUT(1024)) dut (
        .KEY          ({clk, rst_n}),
        .SEG          (seg),
        .DIG          (dig),
        .VALUE        (value),
        .FRAME_VALID  (frame_valid),
        .ERR          (err),
        .BLANK        (blank),
        .DP           (dp),
        .TIMEOUT_FLAG (timeout_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid === 1'b1) fv_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dwell(input int d, input logic [7:0] s, input int n);
        logic [N-1:0] m;
        m    = '1;
        m[d] = 1'b0;
        dig  = m;
        seg  = s;
        cyc(n);
    endtask

    task automatic idle(input int n);
        dig = '1;
        seg = 8'hFF;
        cyc(n);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        rst_n = 1'b0;
        dig   = '1;
        seg   = 8'hFF;
        cyc(3);
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_blank", 32'(blank), 32'h0);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_tflag", 32'(timeout_flag), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // Basic scan of 1..6
        fv_base = fv_cnt;
        dwell(0, 8'hF9, 8); dwell(1, 8'hA4, 8); dwell(2, 8'hB0, 8);
        dwell(3, 8'h99, 8); dwell(4, 8'h92, 8); dwell(5, 8'h82, 8);
        idle(3);
        chk("scan1_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("scan1_value", 32'(value), 32'h654321);
        chk("scan1_err", 32'(err), 32'h0);
        chk("scan1_blank", 32'(blank), 32'h0);
        chk("scan1_dp", 32'(dp), 32'h0);

        // Digit 2 dwell one short of settling: no accept, no frame
        fv_base = fv_cnt;
        dwell(0, 8'hF9, 8); dwell(1, 8'hA4, 8); dwell(2, 8'h86, 3);
        dwell(3, 8'h99, 8); dwell(4, 8'h92, 8); dwell(5, 8'h82, 8);
        idle(3);
        chk("short_fv", 32'(fv_cnt - fv_base), 32'd0);
        // Second scan completes the frame at digit 2 (3..5 still seen from before)
        dwell(0, 8'hF8, 8); dwell(1, 8'h80, 8); dwell(2, 8'h90, 8);
        dwell(3, 8'h88, 8); dwell(4, 8'h83, 8); dwell(5, 8'hC6, 8);
        idle(3);
        chk("short_rescan_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("short_rescan_value", 32'(value), 32'h654987);

        pulse_reset();
        chk("midreset_value", 32'(value), 32'h0);

        // Blank with DP on digit 3, garbage on digit 4
        fv_base = fv_cnt;
        dwell(0, 8'hF9, 8); dwell(1, 8'hA4, 8); dwell(2, 8'hB0, 8);
        dwell(3, 8'h7F, 8); dwell(4, 8'hAA, 8); dwell(5, 8'h82, 8);
        idle(3);
        chk("glyph_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("glyph_value", 32'(value), 32'h600321);
        chk("glyph_blank", 32'(blank), 32'h08);
        chk("glyph_dp", 32'(dp), 32'h08);
        chk("glyph_err", 32'(err), 32'h10);

        // Two digits selected at once must not accept either
        fv_base = fv_cnt;
        dwell(2, 8'hB0, 8); dwell(3, 8'h99, 8); dwell(4, 8'h92, 8); dwell(5, 8'h82, 8);
        dig = 6'b111100;
        seg = 8'hC0;
        cyc(20);
        chk("multisel_fv", 32'(fv_cnt - fv_base), 32'd0);
        dwell(0, 8'hF9, 8); dwell(1, 8'hA4, 8);
        idle(3);
        chk("multisel_done_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("multisel_value", 32'(value), 32'h654321);
        chk("multisel_err", 32'(err), 32'h0);
        chk("multisel_blank", 32'(blank), 32'h0);

        // Partial frame then long idle -> timeout
        fv_base = fv_cnt;
        dwell(0, 8'hC0, 8); dwell(1, 8'hF9, 8); dwell(2, 8'hA4, 8);
        idle(500);
        chk("to_early_flag", 32'(timeout_flag), 32'h0);
        idle(600);
        chk("to_flag", 32'(timeout_flag), 32'h1);
        chk("to_value_kept", 32'(value), 32'h654321);
        chk("to_fv", 32'(fv_cnt - fv_base), 32'd0);
        dwell(0, 8'hC0, 8); dwell(1, 8'hF9, 8); dwell(2, 8'hA4, 8);
        dwell(3, 8'hB0, 8); dwell(4, 8'h99, 8); dwell(5, 8'h92, 8);
        idle(3);
        chk("to_rescan_fv", 32'(fv_cnt - fv_base), 32'd1);
        chk("to_rescan_flag", 32'(timeout_flag), 32'h0);
        chk("to_rescan_value", 32'(value), 32'h543210);

        // Reset after four accepts discards the partial frame
        fv_base = fv_cnt;
        dwell(0, 8'hF9, 8); dwell(1, 8'hA4, 8); dwell(2, 8'hB0, 8); dwell(3, 8'h99, 8);
        rst_n = 1'b0;
        cyc(2);
        chk("rst2_value", 32'(value), 32'h0);
        rst_n = 1'b1;
        cyc(1);
        dwell(4, 8'h92, 8); dwell(5, 8'h82, 8);
        idle(3);
        chk("rst2_fv", 32'(fv_cnt - fv_base), 32'd0);
        chk("rst2_value_after", 32'(value), 32'h0);
        chk("rst2_err", 32'(err), 32'h0);
        chk("rst2_blank", 32'(blank), 32'h0);
        chk("rst2_dp", 32'(dp), 32'h0);
        chk("rst2_tflag", 32'(timeout_flag), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
